// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Two-source (EXU / LSU) writeback arbiter sharing a single
//                register-file write port. Each source feeds a 1-entry
//                holding buffer; buffers are drained oldest-first with
//                round-robin on ties. Provides RAW-hazard flags for two
//                decode source indices against every in-flight write.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            exu_valid,
    output logic            exu_ready,
    input  logic [4:0]      exu_rd,
    input  logic [XLEN-1:0] exu_data,

    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,

    output logic            rf_wen,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_data,

    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    output logic            hazard_rs1,
    output logic            hazard_rs2
);

    // Identifies a writeback source; used for the age and round-robin state.
    typedef enum logic {
        SRC_EXU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    // ------------------------------------------------------------------
    // Holding buffers
    // ------------------------------------------------------------------
    logic            r_exu_vld;
    logic [4:0]      r_exu_rd;
    logic [XLEN-1:0] r_exu_data;

    logic            r_lsu_vld;
    logic [4:0]      r_lsu_rd;
    logic [XLEN-1:0] r_lsu_data;

    // ------------------------------------------------------------------
    // Arbitration state
    // ------------------------------------------------------------------
    src_e            r_older;   // older buffer when both are valid and no tie
    logic            r_tie;     // both buffers were filled on the same edge
    src_e            r_rr;      // source granted on the most recent tie

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic            r_rf_wen;
    logic [4:0]      r_rf_rd;
    logic [XLEN-1:0] r_rf_data;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic            w_both_vld;
    logic            w_gnt_exu;
    logic            w_gnt_lsu;
    logic            w_any_gnt;
    logic            w_tie_gnt;
    logic            w_exu_acc;
    logic            w_lsu_acc;
    logic            w_exu_load;
    logic            w_lsu_load;
    logic [4:0]      w_gnt_rd;
    logic [XLEN-1:0] w_gnt_data;

    assign w_both_vld = r_exu_vld & r_lsu_vld;

    // Grant selection: single valid buffer wins, otherwise oldest-first,
    // and on a tie the source that did not win the previous tie.
    always_comb begin
        w_gnt_exu = 1'b0;
        w_gnt_lsu = 1'b0;
        if (w_both_vld) begin
            if (r_tie) begin
                if (r_rr == SRC_EXU) begin
                    w_gnt_lsu = 1'b1;
                end else begin
                    w_gnt_exu = 1'b1;
                end
            end else if (r_older == SRC_EXU) begin
                w_gnt_exu = 1'b1;
            end else begin
                w_gnt_lsu = 1'b1;
            end
        end else if (r_exu_vld) begin
            w_gnt_exu = 1'b1;
        end else if (r_lsu_vld) begin
            w_gnt_lsu = 1'b1;
        end
    end

    assign w_any_gnt = w_gnt_exu | w_gnt_lsu;
    assign w_tie_gnt = w_both_vld & r_tie;

    // Granted buffer contents routed to the output stage.
    always_comb begin
        w_gnt_rd   = r_lsu_rd;
        w_gnt_data = r_lsu_data;
        if (w_gnt_exu) begin
            w_gnt_rd   = r_exu_rd;
            w_gnt_data = r_exu_data;
        end
    end

    // A buffer can accept when empty or when it is being drained this cycle.
    assign exu_ready = ~rst & (~r_exu_vld | w_gnt_exu);
    assign lsu_ready = ~rst & (~r_lsu_vld | w_gnt_lsu);

    assign w_exu_acc = exu_valid & exu_ready;
    assign w_lsu_acc = lsu_valid & lsu_ready;

    // Writes to x0 complete the handshake but never occupy a buffer.
    assign w_exu_load = w_exu_acc & (exu_rd != 5'd0);
    assign w_lsu_load = w_lsu_acc & (lsu_rd != 5'd0);

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // EXU buffer: load on accepted non-x0 write, clear when granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exu_vld  <= 1'b0;
            r_exu_rd   <= 5'd0;
            r_exu_data <= '0;
        end else if (w_exu_load) begin
            r_exu_vld  <= 1'b1;
            r_exu_rd   <= exu_rd;
            r_exu_data <= exu_data;
        end else if (w_gnt_exu) begin
            r_exu_vld  <= 1'b0;
        end
    end

    // LSU buffer: load on accepted non-x0 write, clear when granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lsu_vld  <= 1'b0;
            r_lsu_rd   <= 5'd0;
            r_lsu_data <= '0;
        end else if (w_lsu_load) begin
            r_lsu_vld  <= 1'b1;
            r_lsu_rd   <= lsu_rd;
            r_lsu_data <= lsu_data;
        end else if (w_gnt_lsu) begin
            r_lsu_vld  <= 1'b0;
        end
    end

    // Age / tie / round-robin tracking. A buffer loaded alone is always the
    // younger one; the age bit only matters when both end up valid. Two
    // buffers still valid with neither loaded cannot happen, since one of
    // them is always granted, so that case simply holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_older <= SRC_EXU;
            r_tie   <= 1'b0;
            r_rr    <= SRC_EXU;
        end else begin
            if (w_tie_gnt) begin
                r_rr <= w_gnt_exu ? SRC_EXU : SRC_LSU;
            end
            if (w_exu_load && w_lsu_load) begin
                r_tie <= 1'b1;
            end else if (w_exu_load) begin
                r_tie   <= 1'b0;
                r_older <= SRC_LSU;
            end else if (w_lsu_load) begin
                r_tie   <= 1'b0;
                r_older <= SRC_EXU;
            end
        end
    end

    // Registered write port: pulses wen on a grant, holds index/data otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_wen  <= 1'b0;
            r_rf_rd   <= 5'd0;
            r_rf_data <= '0;
        end else if (w_any_gnt) begin
            r_rf_wen  <= 1'b1;
            r_rf_rd   <= w_gnt_rd;
            r_rf_data <= w_gnt_data;
        end else begin
            r_rf_wen  <= 1'b0;
        end
    end

    assign rf_wen  = r_rf_wen;
    assign rf_rd   = r_rf_rd;
    assign rf_data = r_rf_data;

    // ------------------------------------------------------------------
    // RAW hazard detection. The output stage counts as pending because
    // its write only lands in the register file at the next edge.
    // ------------------------------------------------------------------
    function automatic logic f_pending(input logic [4:0] rs);
        logic v_hit;
        v_hit = (r_exu_vld & (r_exu_rd == rs))
              | (r_lsu_vld & (r_lsu_rd == rs))
              | (r_rf_wen  & (r_rf_rd  == rs));
        return (rs != 5'd0) & v_hit;
    endfunction

    // Combinational hazard flags for both decode source indices.
    always_comb begin
        hazard_rs1 = f_pending(chk_rs1);
        hazard_rs2 = f_pending(chk_rs2);
    end

endmodule
`default_nettype wire
